axi_txn_tracker: RTL and testbench

Transaction-completion tracker that generates `endtrans` for the system control unit (`scu`) arbiter. It sits on the interconnect's muxed master-to-slave channel, downstream of the grant mux. It watches the AXI handshakes of whichever master `mas_sel` currently grants, follows one write or read transaction from address to final response, and pulses `endtrans` so the arbiter can release or re-arbitrate the bus. It also flags burst-length mismatches and, optionally, stalled transactions.

---
 rtl/scu_pkg.sv | 25 ++
 rtl/beat_counter.sv | 50 +++++
 rtl/axi_txn_tracker.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_txn_tracker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scu_pkg.sv
// Shared definitions for the scu transaction tracker: FSM state encoding,
// master-select encodings and the default AxLEN width.
package scu_pkg;

  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] MSEL_NONE = 2'b00;
  localparam logic [1:0] MSEL_M1   = 2'b01;
  localparam logic [1:0] MSEL_M2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } txn_state_e;

  // A grant is live only for M1 or M2; 00 and 11 both mean "no master".
  function automatic logic msel_granted(input logic [1:0] sel);
    return (sel == MSEL_M1) || (sel == MSEL_M2);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter shared by the write and read paths of axi_txn_tracker.
// Holds the latched burst length and the number of completed beats; the
// count is one bit wider than AxLEN so a 256-beat burst fits, and it
// saturates instead of wrapping. at_len is high while the next beat is the
// one that must carry LAST.
module beat_counter
  import scu_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic [LEN_W-1:0] len_in,
  input  logic             inc,
  output logic             at_len
);

  localparam logic [LEN_W:0] CNT_MAX  = {(LEN_W+1){1'b1}};
  localparam logic [LEN_W:0] CNT_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

  logic [LEN_W:0]   count_r;
  logic [LEN_W-1:0] len_r;

  // Beat count and burst length registers; clear beats load, saturate at max.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= CNT_ZERO;
      len_r   <= {LEN_W{1'b0}};
    end else begin
      if (clr) begin
        count_r <= CNT_ZERO;
      end else if (inc && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
      if (load) begin
        len_r <= len_in;
      end else begin
        len_r <= len_r;
      end
    end
  end

  assign at_len = (count_r == {1'b0, len_r});

endmodule

// File: rtl/axi_txn_tracker.sv
// AXI transaction-completion tracker for the scu arbiter. Follows one write
// (AW -> W beats -> B) or read (AR -> R beats) of the granted master and
// pulses endtrans for one cycle after the final handshake. A grant change
// while busy aborts silently. len_err is sticky on LAST/length mismatch.
// Optional watchdog: define AXI_TXN_TIMEOUT_EN to add the timeout port and
// force completion after TIMEOUT_CYC cycles without handshake progress.
module axi_txn_tracker
  import scu_pkg::*;
#(
  parameter int LEN_W       = LEN_W_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       mas_sel,
  input  logic             awvalid,
  input  logic             awready,
  input  logic [LEN_W-1:0] awlen,
  input  logic             wvalid,
  input  logic             wready,
  input  logic             wlast,
  input  logic             bvalid,
  input  logic             bready,
  input  logic             arvalid,
  input  logic             arready,
  input  logic [LEN_W-1:0] arlen,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  output logic             endtrans,
  output logic             busy,
  output logic             len_err
`ifdef AXI_TXN_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  txn_state_e       state_r;
  txn_state_e       state_s;
  logic [1:0]       sel_r;
  logic             endtrans_r;
  logic             busy_r;
  logic             len_err_r;

  logic             aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic             abort_s;
  logic             wd_fire_s;
  logic             err_set_s;
  logic             cnt_clr_s;
  logic             cnt_load_s;
  logic             cnt_inc_s;
  logic [LEN_W-1:0] cnt_len_s;
  logic             at_len_s;

  assign aw_hs_s = awvalid && awready;
  assign w_hs_s  = wvalid  && wready;
  assign b_hs_s  = bvalid  && bready;
  assign ar_hs_s = arvalid && arready;
  assign r_hs_s  = rvalid  && rready;

  // Grant seen at transaction start is held in sel_r; any change aborts.
  // DONE is excluded: the completion has already been committed.
  assign abort_s = (state_r != IDLE) && (state_r != DONE) && (mas_sel != sel_r);

  beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (cnt_clr_s),
    .load   (cnt_load_s),
    .len_in (cnt_len_s),
    .inc    (cnt_inc_s),
    .at_len (at_len_s)
  );

  // Next-state, counter control and length-check decode; abort beats watchdog.
  always_comb begin
    state_s    = state_r;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_len_s  = awlen;
    err_set_s  = 1'b0;
    if (abort_s) begin
      state_s   = IDLE;
      cnt_clr_s = 1'b1;
    end else if (wd_fire_s) begin
      state_s = DONE;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_clr_s = 1'b1;
          if (!msel_granted(mas_sel)) begin
            state_s = IDLE;
          end else if (aw_hs_s) begin
            state_s    = WR_DATA;
            cnt_load_s = 1'b1;
            cnt_len_s  = awlen;
          end else if (awvalid) begin
            state_s = WR_ADDR;
          end else if (ar_hs_s) begin
            state_s    = RD_DATA;
            cnt_load_s = 1'b1;
            cnt_len_s  = arlen;
          end else begin
            state_s = IDLE;
          end
        end
        WR_ADDR: begin
          // Early W beats are counted; the length check starts after AW.
          cnt_inc_s = w_hs_s;
          if (aw_hs_s) begin
            state_s    = WR_DATA;
            cnt_load_s = 1'b1;
            cnt_len_s  = awlen;
          end else begin
            state_s = WR_ADDR;
          end
        end
        WR_DATA: begin
          if (w_hs_s) begin
            cnt_inc_s = 1'b1;
            err_set_s = (wlast != at_len_s);
            state_s   = wlast ? WR_RESP : WR_DATA;
          end else begin
            state_s = WR_DATA;
          end
        end
        WR_RESP: begin
          if (b_hs_s) begin
            state_s = DONE;
          end else begin
            state_s = WR_RESP;
          end
        end
        RD_DATA: begin
          if (r_hs_s) begin
            cnt_inc_s = 1'b1;
            err_set_s = (rlast != at_len_s);
            state_s   = rlast ? DONE : RD_DATA;
          end else begin
            state_s = RD_DATA;
          end
        end
        DONE: begin
          state_s   = IDLE;
          cnt_clr_s = 1'b1;
        end
        default: begin
          state_s   = IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State, latched grant and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= IDLE;
      sel_r      <= MSEL_NONE;
      endtrans_r <= 1'b0;
      busy_r     <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE) begin
        sel_r <= mas_sel;
      end else begin
        sel_r <= sel_r;
      end
      endtrans_r <= (state_s == DONE);
      busy_r     <= (state_s != IDLE);
      len_err_r  <= len_err_r || err_set_s;
    end
  end

  assign endtrans = endtrans_r;
  assign busy     = busy_r;
  assign len_err  = len_err_r;

`ifdef AXI_TXN_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 32'sd1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(32'd1);

  logic [WD_W-1:0] wd_r;
  logic            timeout_r;
  logic            wd_active_s;
  logic            progress_s;

  assign wd_active_s = (state_r == WR_ADDR) || (state_r == WR_DATA) ||
                       (state_r == WR_RESP) || (state_r == RD_DATA);
  assign progress_s  = aw_hs_s || w_hs_s || b_hs_s || ar_hs_s || r_hs_s;
  assign wd_fire_s   = wd_active_s && !progress_s && (wd_r == WD_LIMIT);

  // Watchdog: count consecutive stalled tracking cycles, latch sticky timeout.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_r      <= {WD_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      if (!wd_active_s || progress_s || wd_fire_s || abort_s) begin
        wd_r <= {WD_W{1'b0}};
      end else begin
        wd_r <= wd_r + WD_ONE;
      end
      if (wd_fire_s && !abort_s) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end

  assign timeout = timeout_r;
`else
  logic unused_timeout_cfg;

  assign wd_fire_s          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 32'sd0);
`endif

endmodule

// File: tb/tb_axi_txn_tracker.sv
// Self-checking bench for axi_txn_tracker. The reference model works at
// transaction level: a pulse is expected exactly one cycle after the final
// handshake, and len_err is expected (sticky) whenever the number of beats
// driven differs from AxLEN+1. Build with +define+AXI_TXN_TIMEOUT_EN to
// exercise the watchdog (TIMEOUT_CYC is fixed at 16 here).
module tb_axi_txn_tracker;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       mas_sel;
  logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic             arvalid, arready, rvalid, rready, rlast;
  logic [LEN_W-1:0] awlen, arlen;
  logic             endtrans, busy, len_err;
`ifdef AXI_TXN_TIMEOUT_EN
  logic             timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses[$];
  bit exp_err;

  axi_txn_tracker #(.LEN_W(LEN_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rstn(rstn), .mas_sel(mas_sel),
    .awvalid(awvalid), .awready(awready), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .endtrans(endtrans), .busy(busy), .len_err(len_err)
`ifdef AXI_TXN_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge index preceding every cycle in which endtrans is high.
  always @(negedge clk) if (endtrans === 1'b1) pulses.push_back(cyc);

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mas_sel = 2'b00; awvalid = 1'b0; awready = 1'b0; awlen = '0;
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
    arvalid = 1'b0; arready = 1'b0; arlen = '0;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    exp_err = 1'b0;
    pulses.delete();
  endtask

  // Drive one write; fin = edge of the B handshake, busy_all = busy held from AW accept through DONE.
  task automatic drive_write(input logic [1:0] sel, input int len, input int nbeats,
                             input int aw_wait, input int stall_max, input int b_wait,
                             output int fin, output bit busy_all);
    busy_all = 1'b1;
    mas_sel = sel; awvalid = 1'b1; awlen = LEN_W'(len);
    for (int k = 0; k < aw_wait; k++) begin
      awready = 1'b0; tick(); busy_all &= (busy === 1'b1);
    end
    awready = 1'b1; tick(); busy_all &= (busy === 1'b1);
    awvalid = 1'b0; awready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      int st;
      st = $urandom_range(stall_max, 0);
      for (int s = 0; s < st; s++) begin
        wvalid = 1'($urandom_range(1, 0)); wready = 1'b0; wlast = 1'b0;
        tick(); busy_all &= (busy === 1'b1);
      end
      wvalid = 1'b1; wready = 1'b1; wlast = (b == nbeats - 1);
      tick(); busy_all &= (busy === 1'b1);
    end
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    bvalid = 1'b1;
    for (int k = 0; k < b_wait; k++) begin
      bready = 1'b0; tick(); busy_all &= (busy === 1'b1);
    end
    bready = 1'b1; tick(); fin = cyc; busy_all &= (busy === 1'b1);
    bvalid = 1'b0; bready = 1'b0;
    tick();
  endtask

  // Drive one read; fin = edge of the last R handshake.
  task automatic drive_read(input logic [1:0] sel, input int len, input int nbeats,
                            input int stall_max, output int fin, output bit busy_all);
    busy_all = 1'b1;
    mas_sel = sel; arvalid = 1'b1; arready = 1'b1; arlen = LEN_W'(len);
    tick(); busy_all &= (busy === 1'b1);
    arvalid = 1'b0; arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      int st;
      st = $urandom_range(stall_max, 0);
      for (int s = 0; s < st; s++) begin
        rvalid = 1'b1; rready = 1'b0; rlast = 1'b0;
        tick(); busy_all &= (busy === 1'b1);
      end
      rvalid = 1'b1; rready = 1'b1; rlast = (b == nbeats - 1);
      tick(); busy_all &= (busy === 1'b1);
    end
    fin = cyc;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (endtrans !== 1'b0) begin n_fail++; $display("FAIL reset_endtrans: got %b want 0", endtrans); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b want 0", len_err); end
`ifdef AXI_TXN_TIMEOUT_EN
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
    // Handshakes without a live grant (00 and 11) must be ignored.
    awvalid = 1'b1; awready = 1'b1; arvalid = 1'b1; arready = 1'b1;
    mas_sel = 2'b00; tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nogrant00_busy: got %b want 0", busy); end
    mas_sel = 2'b11; tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nogrant11_busy: got %b want 0", busy); end
    idle_inputs(); tick();
    n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL nogrant_pulses: got %0d want 0", pulses.size()); end
  endtask

  task automatic test_single_write();
    int fin; bit ba;
    do_reset();
    drive_write(2'b01, 0, 1, 0, 0, 0, fin, ba);
    n_checks++; if (pulses.size() != 1 || pulses[0] != fin) begin n_fail++; $display("FAIL single_write_pulse: got %0d pulses first@%0d want 1 @%0d", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, fin); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL single_write_len_err: got %b want 0", len_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read4();
    int fin; bit ba;
    do_reset();
    drive_read(2'b10, 3, 4, 1, fin, ba);
    n_checks++; if (pulses.size() != 1 || pulses[0] != fin) begin n_fail++; $display("FAIL read4_pulse: got %0d pulses want 1 @%0d", pulses.size(), fin); end
    n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL read4_busy_span: got %b want 1", ba); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL read4_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_len_mismatch();
    int fin; bit ba;
    do_reset();
    drive_write(2'b01, 3, 2, 0, 0, 1, fin, ba);
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_len_err: got %b want 1", len_err); end
    n_checks++; if (pulses.size() != 1 || pulses[0] != fin) begin n_fail++; $display("FAIL mismatch_pulse: got %0d pulses want 1 @%0d", pulses.size(), fin); end
    pulses.delete();
    drive_write(2'b10, 1, 2, 0, 0, 0, fin, ba);
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %b want 1", len_err); end
    // Too many beats: a beat at index len without LAST.
    do_reset();
    drive_read(2'b01, 1, 3, 0, fin, ba);
    n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL overlong_len_err: got %b want 1", len_err); end
  endtask

  task automatic test_grant_drop();
    int fin; bit ba;
    do_reset();
    mas_sel = 2'b01; awvalid = 1'b1; awready = 1'b1; awlen = 8'd3; tick();
    awvalid = 1'b0; awready = 1'b0;
    wvalid = 1'b1; wready = 1'b1; tick();
    wvalid = 1'b0; wready = 1'b0;
    mas_sel = 2'b00; tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy); end
    tick(); tick();
    n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL drop_no_pulse: got %0d pulses want 0", pulses.size()); end
    // Final B handshake coinciding with a grant change: abort wins.
    mas_sel = 2'b10; awvalid = 1'b1; awready = 1'b1; awlen = 8'd0; tick();
    awvalid = 1'b0; awready = 1'b0;
    wvalid = 1'b1; wready = 1'b1; wlast = 1'b1; tick();
    wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
    bvalid = 1'b1; bready = 1'b1; mas_sel = 2'b01; tick();
    bvalid = 1'b0; bready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL final_hs_abort_busy: got %b want 0", busy); end
    tick();
    n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL final_hs_abort_pulse: got %0d pulses want 0", pulses.size()); end
    // Recovery after abort: a clean 2-beat write completes without error.
    drive_write(2'b01, 1, 2, 0, 0, 0, fin, ba);
    n_checks++; if (pulses.size() != 1 || pulses[0] != fin || len_err !== 1'b0) begin n_fail++; $display("FAIL drop_recover: got %0d pulses len_err=%b want 1 pulse @%0d len_err=0", pulses.size(), len_err, fin); end
  endtask

  task automatic test_simultaneous();
    int fw, fr; bit ba;
    do_reset();
    arvalid = 1'b1; arready = 1'b1; arlen = 8'd1;
    drive_write(2'b01, 0, 1, 0, 0, 0, fw, ba);
    drive_read(2'b01, 1, 2, 0, fr, ba);
    n_checks++; if (pulses.size() != 2) begin n_fail++; $display("FAIL simul_pulse_count: got %0d want 2", pulses.size()); end
    n_checks++; if (pulses.size() == 2 && (pulses[0] != fw || pulses[1] != fr)) begin n_fail++; $display("FAIL simul_pulse_order: got %0d,%0d want %0d,%0d", pulses[0], pulses[1], fw, fr); end
  endtask

  task automatic test_back_to_back();
    int f1, f2; bit ba;
    do_reset();
    drive_write(2'b10, 0, 1, 0, 0, 0, f1, ba);
    drive_write(2'b10, 0, 1, 0, 0, 0, f2, ba);
    n_checks++; if (f2 - f1 != 4) begin n_fail++; $display("FAIL b2b_period: got %0d want 4", f2 - f1); end
    n_checks++; if (pulses.size() != 2 || pulses[0] != f1 || pulses[1] != f2) begin n_fail++; $display("FAIL b2b_pulses: got %0d pulses want 2 @%0d,%0d", pulses.size(), f1, f2); end
  endtask

  task automatic test_long_burst();
    int fin; bit ba;
    do_reset();
    drive_read(2'b10, 255, 256, 0, fin, ba);
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL long_burst_len_err: got %b want 0", len_err); end
    n_checks++; if (pulses.size() != 1 || pulses[0] != fin) begin n_fail++; $display("FAIL long_burst_pulse: got %0d pulses want 1 @%0d", pulses.size(), fin); end
  endtask

  task automatic test_random();
    int fin, len, nb, kind; bit ba; logic [1:0] sel;
    for (int i = 0; i < 32; i++) begin
      if (i % 8 == 0) do_reset();
      kind = $urandom_range(1, 0);
      sel  = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
      len  = $urandom_range(7, 0);
      nb   = ($urandom_range(3, 0) == 0) ? $urandom_range(len + 2, 1) : len + 1;
      exp_err = exp_err | (nb != len + 1);
      pulses.delete();
      if (kind == 0) drive_write(sel, len, nb, $urandom_range(2, 0), 2, $urandom_range(2, 0), fin, ba);
      else           drive_read(sel, len, nb, 2, fin, ba);
      n_checks++; if (pulses.size() != 1 || pulses[0] != fin) begin n_fail++; $display("FAIL rand%0d_pulse: got %0d pulses want 1 @%0d", i, pulses.size(), fin); end
      n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL rand%0d_busy_span: got %b want 1", i, ba); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy_end: got %b want 0", i, busy); end
      n_checks++; if (len_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_len_err: got %b want %b (len=%0d beats=%0d)", i, len_err, exp_err, len, nb); end
    end
  endtask

  task automatic test_reset_mid();
    int fin; bit ba;
    do_reset();
    drive_write(2'b01, 3, 2, 0, 0, 0, fin, ba);
    pulses.delete();
    mas_sel = 2'b10; arvalid = 1'b1; arready = 1'b1; arlen = 8'd7; tick();
    arvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b1; rready = 1'b1; tick(); tick();
    rlast = 1'b1; rstn = 1'b0; tick();
    idle_inputs();
    n_checks++; if (busy !== 1'b0 || endtrans !== 1'b0 || len_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_outputs: got busy=%b endtrans=%b len_err=%b want 0 0 0", busy, endtrans, len_err); end
    rstn = 1'b1; tick(); tick();
    n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL reset_mid_pulse: got %0d want 0", pulses.size()); end
    exp_err = 1'b0;
  endtask

`ifdef AXI_TXN_TIMEOUT_EN
  task automatic test_timeout();
    int a;
    do_reset();
    mas_sel = 2'b01; awvalid = 1'b1; awready = 1'b1; awlen = 8'd0; tick();
    a = cyc;
    awvalid = 1'b0; awready = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    n_checks++; if (timeout !== 1'b0 || pulses.size() != 0) begin n_fail++; $display("FAIL timeout_early: got timeout=%b pulses=%0d want 0 0", timeout, pulses.size()); end
    tick();
    n_checks++; if (timeout !== 1'b1 || endtrans !== 1'b1) begin n_fail++; $display("FAIL timeout_fire: got timeout=%b endtrans=%b want 1 1", timeout, endtrans); end
    tick();
    n_checks++; if (pulses.size() != 1 || pulses[0] != a + 16 || busy !== 1'b0 || timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_after: got %0d pulses busy=%b timeout=%b want 1 @%0d busy=0 timeout=1", pulses.size(), busy, timeout, a + 16); end
    rstn = 1'b0; tick(); rstn = 1'b1;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_reset: got %b want 0", timeout); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    mas_sel = 2'b01; awvalid = 1'b1; awready = 1'b1; awlen = 8'd0; tick();
    awvalid = 1'b0; awready = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    n_checks++; if (busy !== 1'b1 || pulses.size() != 0) begin n_fail++; $display("FAIL no_timeout_wait: got busy=%b pulses=%0d want 1 0", busy, pulses.size()); end
    mas_sel = 2'b00; tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_timeout_recover: got %b want 0", busy); end
  endtask
`endif

  initial begin
    idle_inputs();
    rstn = 1'b0;
    exp_err = 1'b0;
    test_reset();
    test_single_write();
    test_read4();
    test_len_mismatch();
    test_grant_drop();
    test_simultaneous();
    test_back_to_back();
    test_long_burst();
    test_random();
    test_reset_mid();
`ifdef AXI_TXN_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
